// File: rtl/execute_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide,
// 32 CALC cycles plus one sign-fix cycle, with one-edge divide-by-zero/overflow exits.
module execute_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        need_dstE_i,
  input  logic [4:0]  dstE_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        need_dstE_o,
  output logic [4:0]  dstE_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [5:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_result;
  logic        r_need_dst;
  logic [4:0]  r_dst;

  logic        w_accept;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic [32:0] w_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [63:0] w_div_step;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_fix_res;

  // Operand signedness: MULHU/DIVU/REMU unsigned in both, MULHSU unsigned in rs2.
  assign w_sign_a = rs1_data_i[31] & ~(op_i[0] & (op_i[1] | op_i[2]));
  assign w_sign_b = rs2_data_i[31] & ((~op_i[2] & ~op_i[1]) | (op_i[2] & ~op_i[0]));
  assign w_mag_a  = w_sign_a ? (~rs1_data_i + 32'd1) : rs1_data_i;
  assign w_mag_b  = w_sign_b ? (~rs2_data_i + 32'd1) : rs2_data_i;

  assign w_div_zero = op_i[2] & (rs2_data_i == 32'd0);
  assign w_div_ovf  = op_i[2] & ~op_i[0] & (rs1_data_i == 32'h8000_0000) &
                      (rs2_data_i == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero)
      w_special_res = op_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
    else if (w_div_ovf)
      w_special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // Multiply: {acc_hi, multiplier} shifts right, multiplicand added into the top.
  assign w_sum      = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_a : 32'd0)};
  assign w_mul_step = {w_sum, r_prod[31:1]};

  // Divide: {remainder, dividend/quotient} shifts left, trial subtract of divisor.
  assign w_shift    = {r_prod[63:32], r_prod[31]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_diff[32];
  assign w_div_step = {(w_qbit ? w_diff[31:0] : w_shift[31:0]), r_prod[30:0], w_qbit};

  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? (~r_prod + 64'd1) : r_prod;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? (~r_prod[31:0] + 32'd1) : r_prod[31:0];
  assign w_rem_fix  = r_sign_a ? (~r_prod[63:32] + 32'd1) : r_prod[63:32];

  always_comb begin
    w_fix_res = 32'd0;
    if (r_op[2])
      w_fix_res = r_op[1] ? w_rem_fix : w_quo_fix;
    else
      w_fix_res = (r_op[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32];
  end

  assign w_accept = (r_state == IDLE) & start_i & ~flush_i;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = w_special ? DONE : CALC;
      CALC: if (r_cnt == 6'd31) w_next_state = FIX;
      FIX:  w_next_state = DONE;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush_i) w_next_state = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op       <= 3'd0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_cnt      <= 6'd0;
      r_prod     <= 64'd0;
      r_result   <= 32'd0;
      r_need_dst <= 1'b0;
      r_dst      <= 5'd0;
    end else if (flush_i) begin
      r_cnt <= 6'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op       <= op_i;
            r_a        <= w_mag_a;
            r_b        <= w_mag_b;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            r_need_dst <= need_dstE_i;
            r_dst      <= dstE_i;
            r_cnt      <= 6'd0;
            r_prod     <= {32'd0, (op_i[2] ? w_mag_a : w_mag_b)};
            if (w_special) r_result <= w_special_res;
          end
        end
        CALC: begin
          r_prod <= r_op[2] ? w_div_step : w_mul_step;
          r_cnt  <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
        end
        FIX:     r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign stall_o     = (w_accept & ~rst_i) | (r_state == CALC) | (r_state == FIX);
  assign done_o      = (r_state == DONE);
  assign result_o    = r_result;
  assign need_dstE_o = r_need_dst;
  assign dstE_o      = r_dst;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: an arithmetic/latency model checked every cycle,
// plus literal expectations on each operation's result and completion cycle.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic        need_in = 1'b0;
  logic [4:0]  dst_in = 5'd0;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        need_out;
  logic [4:0]  dst_out;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  execute_muldiv dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .flush_i     (flush),
    .op_i        (op),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .need_dstE_i (need_in),
    .dstE_i      (dst_in),
    .stall_o     (stall),
    .done_o      (done),
    .result_o    (result),
    .need_dstE_o (need_out),
    .dstE_o      (dst_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (f)
      3'b000: begin p = 64'(sa * sb); return p[31:0]; end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 32'd0 ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Latency model: m_left counts cycles until the done cycle (34 for iterative ops).
  bit          m_active = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_hold = 32'd0;
  logic        m_need = 1'b0;
  logic [4:0]  m_dst = 5'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_left   <= 0;
      m_hold   <= 32'd0;
      m_need   <= 1'b0;
      m_dst    <= 5'd0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_need   <= need_in;
        m_dst    <= dst_in;
        m_res    <= ref_calc(op, rs1, rs2);
        if (is_special(op, rs1, rs2)) begin
          m_left <= 0;
          m_hold <= ref_calc(op, rs1, rs2);
        end else begin
          m_left <= 33;
        end
      end
    end else if (m_left == 0) begin
      m_active <= 1'b0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_hold <= m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stall", {31'd0, stall},
            {31'd0, ((!m_active && start && !flush && !rst) || (m_active && m_left > 0))});
      check("model_done", {31'd0, done}, {31'd0, (m_active && m_left == 0)});
      check("model_result", result, m_hold);
      check("model_need", {31'd0, need_out}, {31'd0, m_need});
      check("model_dst", {27'd0, dst_out}, {27'd0, m_dst});
    end
  end

  // ev_kind: 0 none, 1 flush, 2 reset, 3 stray start; applied during cycle C<ev_cyc>.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp_res,
                        input int exp_cyc, input int ev_cyc, input int ev_kind);
    int c;
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = f; rs1 = a; rs2 = b; need_in = 1'b1; dst_in = d;
    for (c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      if (c == ev_cyc) begin
        case (ev_kind)
          1: flush = 1'b1;
          2: rst = 1'b1;
          3: begin start = 1'b1; op = 3'b100; dst_in = ~d; need_in = 1'b0; end
          default: ;
        endcase
      end
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (exp_cyc == 0 && c == ev_cyc + 1) break;
    end
    if (exp_cyc > 0) begin
      check({nm, "_cycle"}, 32'(c), 32'(exp_cyc));
      check({nm, "_result"}, result, exp_res);
      check({nm, "_dst"}, {27'd0, dst_out}, {27'd0, d});
    end else begin
      check({nm, "_nodone"}, {31'd0, seen}, 32'd0);
      if (ev_kind == 2) begin
        check({nm, "_rst_result"}, result, 32'd0);
        check({nm, "_rst_dst"}, {27'd0, dst_out}, 32'd0);
      end
    end
    $display("%s op=%b rs1=%h rs2=%h -> result=%h done_cycle=%0d", nm, f, a, b, result,
             seen ? c : -1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_dst", {26'd0, need_out, dst_out}, 32'd0);
    chk_en = 1'b1;

    run_op("mul_7_m3",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 34, 0, 0);
    run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 34, 0, 0);
    run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34, 0, 0);
    run_op("divu_big",     3'b101, 32'hFFFF_FFFE,  32'd2,         5'd7,  32'h7FFF_FFFF, 34, 0, 0);
    run_op("divu_zero",    3'b101, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1,  0, 0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'd0,         1,  0, 0);
    run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1,  0, 0);
    run_op("remu_zero",    3'b111, 32'd5,          32'd0,         5'd11, 32'd5,         1,  0, 0);
    run_op("mulhsu_m1_2",  3'b010, 32'hFFFF_FFFF,  32'd2,         5'd12, 32'hFFFF_FFFF, 34, 0, 0);
    run_op("mulhsu_2_big", 3'b010, 32'd2,          32'hFFFF_FFFF, 5'd13, 32'd1,         34, 0, 0);
    run_op("mulh_min_min", 3'b001, 32'h8000_0000,  32'h8000_0000, 5'd14, 32'h4000_0000, 34, 0, 0);
    run_op("div_7_m2",     3'b100, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'd1,         34, 0, 0);
    run_op("remu_100_7",   3'b111, 32'd100,        32'd7,         5'd17, 32'd2,         34, 0, 0);

    // Flush and start together in IDLE: flush wins, nothing accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'b000; rs1 = 32'd3; rs2 = 32'd3; dst_in = 5'd30;
    @(negedge clk);
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_idle", {31'd0, stall | done}, 32'd0);
    check("flush_start_dst", {27'd0, dst_out}, 32'd17);
    $display("flush_start dst=%0d stall=%b", dst_out, stall);

    run_op("div_flushed",  3'b100, 32'd100,        32'd3,         5'd18, 32'd0,         0,  10, 1);
    run_op("mulh_m2_3",    3'b001, 32'hFFFF_FFFE,  32'd3,         5'd19, 32'hFFFF_FFFF, 34, 0, 0);
    run_op("mul_stray",    3'b000, 32'd1000,       32'd1000,      5'd20, 32'd1000000,   34, 5, 3);
    run_op("mul_reset",    3'b000, 32'd6,          32'd7,         5'd21, 32'd0,         0,  20, 2);
    run_op("mul_after_rst",3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd22, 32'd1,         34, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
